// File: rtl/seq_multiplier.sv
// seq_multiplier: parametrised shift-add multiplier with start/busy/done handshake.
// Operands are converted to magnitudes on accept, multiplied unsigned over
// WIDTH iterations, and the sign is reapplied when the result is registered.
module seq_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     in_A,
    input  logic [WIDTH-1:0]     in_B,
    output logic [2*WIDTH-1:0]   pp,
    output logic                 done,
    output logic                 busy
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]           state;
    logic [1:0]           state_next;
    logic                 accept;
    logic                 calc_last;

    logic [WIDTH-1:0]     mag_a_in;
    logic [WIDTH-1:0]     mag_b_in;
    logic                 neg_in;

    logic [2*WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]     mag_b;
    logic [2*WIDTH-1:0]   acc;
    logic [CW-1:0]        cnt;
    logic                 neg;

    // Operand magnitudes and result sign for a request being accepted this cycle
    always_comb begin
        mag_a_in = in_A;
        mag_b_in = in_B;
        if (signed_mode && in_A[WIDTH-1]) begin
            mag_a_in = ~in_A + WIDTH'(1);
        end
        if (signed_mode && in_B[WIDTH-1]) begin
            mag_b_in = ~in_B + WIDTH'(1);
        end
        neg_in = signed_mode & (in_A[WIDTH-1] ^ in_B[WIDTH-1]);
    end

    // Accept decode and next-state selection
    always_comb begin
        accept     = start && ((state == IDLE) || (state == DONE));
        calc_last  = (state == CALC) && (cnt == '0);
        state_next = state;
        case (state)
            IDLE:    state_next = accept ? CALC : IDLE;
            CALC:    state_next = (cnt == '0) ? DONE : CALC;
            DONE:    state_next = accept ? CALC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Shift-add datapath: the multiplicand shifts left each iteration, which is
    // equivalent to adding magA << (WIDTH - cnt) with cnt counting down from WIDTH
    always_ff @(posedge clk) begin
        if (reset) begin
            mcand <= '0;
            mag_b <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
        end else if (accept) begin
            mcand <= {{WIDTH{1'b0}}, mag_a_in};
            mag_b <= mag_b_in;
            acc   <= '0;
            cnt   <= CW'(WIDTH);
            neg   <= neg_in;
        end else if ((state == CALC) && (cnt != '0)) begin
            if (mag_b[0]) begin
                acc <= acc + mcand;
            end
            mcand <= mcand << 1;
            mag_b <= mag_b >> 1;
            cnt   <= cnt - CW'(1);
        end
    end

    // Result register and handshake outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            pp   <= '0;
            done <= 1'b0;
            busy <= 1'b0;
        end else begin
            done <= 1'b0;
            if (calc_last) begin
                pp   <= neg ? ('0 - acc) : acc;
                done <= 1'b1;
                busy <= 1'b0;
            end else if (accept) begin
                busy <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier: drivers push expected product and
// completion edge, monitors pop and compare whenever done pulses.
module tb_seq_multiplier;

    typedef struct {
        logic [31:0] val;
        int          at;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        start8 = 1'b0, sm8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic [15:0] pp8;
    logic        done8, busy8;

    logic        start16 = 1'b0, sm16 = 1'b0;
    logic [15:0] a16 = '0, b16 = '0;
    logic [31:0] pp16;
    logic        done16, busy16;

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    int k;

    exp_t q8[$];
    exp_t q16[$];
    exp_t e8, e16;

    seq_multiplier #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .start(start8), .signed_mode(sm8),
        .in_A(a8), .in_B(b8), .pp(pp8), .done(done8), .busy(busy8)
    );

    seq_multiplier #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .start(start16), .signed_mode(sm16),
        .in_A(a16), .in_B(b16), .pp(pp16), .done(done16), .busy(busy16)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // 8-bit monitor
    always @(negedge clk) begin
        if (done8) begin
            chk("done8_busy_exclusive", {31'd0, busy8}, 32'd0);
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done8: pp=%0h at edge %0d", pp8, edge_n);
            end else begin
                e8 = q8.pop_front();
                chk("pp8", {16'd0, pp8}, e8.val);
                chk("done8_edge", edge_n, e8.at);
            end
        end
    end

    // 16-bit monitor
    always @(negedge clk) begin
        if (done16) begin
            chk("done16_busy_exclusive", {31'd0, busy16}, 32'd0);
            if (q16.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done16: pp=%0h at edge %0d", pp16, edge_n);
            end else begin
                e16 = q16.pop_front();
                chk("pp16", pp16, e16.val);
                chk("done16_edge", edge_n, e16.at);
            end
        end
    end

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic [15:0] exp);
        @(negedge clk);
        a8 = a; b8 = b; sm8 = sm; start8 = 1'b1;
        if (!busy8) q8.push_back('{val: {16'd0, exp}, at: edge_n + 1 + 9});
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                           input logic [31:0] exp);
        @(negedge clk);
        a16 = a; b16 = b; sm16 = sm; start16 = 1'b1;
        if (!busy16) q16.push_back('{val: exp, at: edge_n + 1 + 17});
        @(negedge clk);
        start16 = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 60 && (q8.size() != 0 || q16.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        chk(name, q8.size() + q16.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_pp8", {16'd0, pp8}, 32'd0);
        chk("reset_busy8", {31'd0, busy8}, 32'd0);
        chk("reset_done8", {31'd0, done8}, 32'd0);
        chk("reset_pp16", pp16, 32'd0);
        chk("reset_busy16", {31'd0, busy16}, 32'd0);

        // Basic unsigned op with busy window and result hold
        issue8(8'h0A, 8'h20, 1'b0, 16'h0140);
        chk("busy8_during", {31'd0, busy8}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("busy8_during", {31'd0, busy8}, 32'd1);
        end
        @(negedge clk);
        repeat (10) @(negedge clk);
        chk("pp8_hold", {16'd0, pp8}, 32'h0140);
        chk("busy8_idle", {31'd0, busy8}, 32'd0);
        wait_idle("t1_complete");

        // Signed corner cases and unsigned all-ones
        issue8(8'h80, 8'h80, 1'b1, 16'h4000);
        wait_idle("t2a_complete");
        issue8(8'h80, 8'h7F, 1'b1, 16'hC080);
        wait_idle("t2b_complete");
        issue8(8'hFF, 8'hFF, 1'b1, 16'h0001);
        wait_idle("t2c_complete");
        issue8(8'hFF, 8'hFF, 1'b0, 16'hFE01);
        wait_idle("t2d_complete");

        // Start while busy ignored; start held through DONE accepted back-to-back
        issue8(8'h0A, 8'h20, 1'b0, 16'h0140);
        k = edge_n;
        repeat (3) @(negedge clk);
        a8 = 8'd3; b8 = 8'd3; start8 = 1'b1;
        @(negedge clk);
        a8 = 8'd3; b8 = 8'd5;
        while (edge_n < k + 9) @(negedge clk);
        q8.push_back('{val: 32'h000F, at: edge_n + 1 + 9});
        @(negedge clk);
        start8 = 1'b0;
        chk("b2b_busy_no_gap", {31'd0, busy8}, 32'd1);
        wait_idle("t3_complete");

        // Reset mid-operation aborts without a done pulse
        issue8(8'd7, 8'd6, 1'b0, 16'h002A);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        q8.delete();
        chk("abort_pp8", {16'd0, pp8}, 32'd0);
        chk("abort_busy8", {31'd0, busy8}, 32'd0);
        chk("abort_done8", {31'd0, done8}, 32'd0);
        repeat (15) @(negedge clk);
        issue8(8'hFD, 8'h05, 1'b1, 16'hFFF1);
        wait_idle("t4_complete");

        // Zero operands keep full latency
        issue8(8'h00, 8'hFF, 1'b0, 16'h0000);
        wait_idle("t6a_complete");
        issue8(8'h00, 8'h80, 1'b1, 16'h0000);
        wait_idle("t6b_complete");

        // 16-bit instance
        issue16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE0001);
        wait_idle("t5a_complete");
        issue16(16'h8000, 16'h0002, 1'b1, 32'hFFFF0000);
        wait_idle("t5b_complete");
        chk("pp16_hold", pp16, 32'hFFFF0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
Name: seq_multiplier

Overview:
Parametrised sequential shift-add multiplier. It is the successor to the fixed 8-bit top_multiplier, adding a configurable operand width, a per-operation signed/unsigned mode, and an explicit start/busy/done handshake. The block takes two WIDTH-bit operands and produces a 2*WIDTH-bit product after a fixed latency. It sits under a controller or CPU-side register block that issues one multiply at a time.

Parameters:
WIDTH, 8, operand width in bits; legal values are 2 to 32; the product is 2*WIDTH bits.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-high reset.
start  in  1  request pulse; sampled only when busy=0.
signed_mode  in  1  0 = unsigned, 1 = two's-complement; sampled together with start.
in_A  in  WIDTH  multiplicand; sampled together with start.
in_B  in  WIDTH  multiplier; sampled together with start.
pp  out  2*WIDTH  product register; holds its value until the next done.
done  out  1  one-cycle pulse; pp is valid from this cycle onward.
busy  out  1  high while an operation is in progress.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, pp=0, done=0, busy=0, internal accumulator and counter cleared.
  - Reset asserted mid-operation aborts the operation.
  - An aborted operation produces no done pulse, and pp returns to 0.
- States: IDLE, CALC, DONE.
- Accept rule: start=1 at a rising edge while state is IDLE or DONE (i.e. busy=0).
  - On accept: latch magA=|in_A|, magB=|in_B|, and neg = signed_mode & (in_A[MSB] ^ in_B[MSB]).
  - On accept: acc=0, cnt=WIDTH, state goes to CALC, busy goes to 1.
  - In unsigned mode the magnitudes are the raw operands.
  - The magnitude of the most negative value (e.g. -128) is held as an unsigned WIDTH-bit number (128), so it does not overflow.
- CALC, once per cycle:
  - If magB[0]=1, acc += magA << (WIDTH-cnt).
  - Then magB >>= 1 and cnt -= 1.
  - acc is 2*WIDTH bits wide and cannot overflow.
  - When cnt reaches 0 after exactly WIDTH CALC edges, state goes to DONE.
- Transition into DONE, on the same edge:
  - pp <= neg ? -acc : acc, computed as 2*WIDTH-bit two's complement.
  - done <= 1, busy <= 0.
- DONE lasts one cycle.
  - If start=1 in this cycle, it is accepted (back-to-back); state goes to CALC, done goes to 0.
  - Otherwise state goes to IDLE and done goes to 0.
- Latency: start sampled at edge k gives pp valid and done=1 after edge k+WIDTH+1.
  - Throughput is one result per WIDTH+1 cycles.
- start while busy=1 is ignored entirely; latched operands and mode are unaffected.
- start held high continuously issues back-to-back operations, re-sampling the inputs at each accept.
- The latency is fixed regardless of operand values: no early termination on zero operands.
- Input changes after the accept edge have no effect on the result.
- busy and done are never both 1.

Test Plan:
1. WIDTH=8, unsigned, in_A=0x0A, in_B=0x20, start pulse at edge k -> busy=1 over edges k+1..k+8; after edge k+9, done=1 for one cycle and pp=0x0140; pp still 0x0140 ten cycles later.
2. WIDTH=8, signed: -128*-128 -> pp=0x4000; -128*127 -> pp=0xC080; -1*-1 -> 0x0001; 0xFF*0xFF unsigned -> 0xFE01; each completes exactly 9 edges after accept.
3. Handshake: second start with A=3, B=3 issued at k+4 during busy -> ignored, first result 0x0140 unchanged; start held high through done cycle -> second op (A=3, B=5) accepted in the DONE cycle, pp=0x000F at k+18, no idle cycle between.
4. Reset mid-op: start at k, reset=1 at edge k+4 -> pp=0, busy=0, done never pulses; a new start after reset release yields the correct result with normal latency.
5. WIDTH=16 instance: unsigned 0xFFFF*0xFFFF -> pp=0xFFFE0001 after edge k+17; signed 0x8000*0x0002 -> pp=0xFFFF0000.
6. Zero operands: 0x00*0xFF unsigned and 0x00*0x80 signed -> pp=0x0000, done still exactly at k+9 (no early termination).
